// File: rtl/sync_bcd_counter.sv
// rtl/sync_bcd_counter.sv - cascaded up/down BCD counter with multiplexed 7-segment scan
module sync_bcd_counter #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] step_val;
   logic [4*DIGITS-1:0] load_clean;
   logic                all9;
   logic                all0;
   logic                carry;
   logic [3:0]          d;
   logic [3:0]          sel_digit;
   logic [15:0]         div;
   logic                scan_wrap;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_nxt;
   logic [DIGITS-1:0]   an_nxt;

   // Ripple the carry/borrow through the decades, sanitise load nibbles, detect terminal states
   always_comb begin
      step_val   = count;
      load_clean = '0;
      all9       = 1'b1;
      all0       = 1'b1;
      carry      = 1'b1;
      d          = '0;
      for (int k = 0; k < DIGITS; k++) begin
         d    = count[4*k +: 4];
         all9 = all9 & (d == 4'd9);
         all0 = all0 & (d == 4'd0);
         load_clean[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd0 : load_val[4*k +: 4];
         if (carry) begin
            if (up) begin
               if (d == 4'd9) begin
                  step_val[4*k +: 4] = 4'd0;
               end else begin
                  step_val[4*k +: 4] = d + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  step_val[4*k +: 4] = 4'd9;
               end else begin
                  step_val[4*k +: 4] = d - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   // Terminal count is combinational so it announces the wrapping edge ahead of time
   always_comb begin
      tc = en & ~load & ~reset & (up ? all9 : all0);
   end

   // Count register: reset beats load, load beats count enable
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_clean;
      end else if (en) begin
         count <= step_val;
      end
   end

   // Next digit slot and its one-hot select, advanced when the divider expires
   always_comb begin
      scan_wrap = (div == 16'(SCAN_DIV - 1));
      idx_nxt   = idx;
      an_nxt    = '0;
      if (scan_wrap) begin
         idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end
      for (int k = 0; k < DIGITS; k++) begin
         an_nxt[k] = (idx_nxt == IW'(k));
      end
   end

   // Free-running scan divider and registered digit select
   always_ff @(posedge clk) begin
      if (reset) begin
         div <= '0;
         idx <= '0;
         an  <= DIGITS'(1);
      end else begin
         div <= scan_wrap ? 16'd0 : div + 16'd1;
         idx <= idx_nxt;
         an  <= an_nxt;
      end
   end

   // Decode the currently selected digit straight from count so updates show without scan delay
   always_comb begin
      sel_digit = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            sel_digit = count[4*k +: 4];
         end
      end
      case (sel_digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      if (reset) begin
         seg = 7'h3F;
      end
   end

endmodule

// File: tb/tb_sync_bcd_counter.sv
// tb/tb_sync_bcd_counter.sv - directed scoreboard bench for sync_bcd_counter
module tb_sync_bcd_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [7:0] count;
   logic       tc;
   logic [1:0] an;
   logic [6:0] seg;

   sync_bcd_counter #(.DIGITS(2), .SCAN_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] count;
      logic [1:0] an;
      logic [6:0] seg;
   } exp_t;

   exp_t q[$];

   logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int tests = 0;
   int fails = 0;
   int m_val = 0;
   int m_div = 0;
   int m_idx = 0;

   task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                        input logic [7:0] lv, input string tag);
      logic exp_tc;
      int   lo;
      int   hi;
      int   dig;
      exp_t ex;
      exp_t got;
      reset    = r;
      en       = e;
      up       = u;
      load     = l;
      load_val = lv;
      #1;
      exp_tc = e && !l && !r && (u ? (m_val == 99) : (m_val == 0));
      tests++;
      assert (tc === exp_tc) else begin
         fails++;
         $error("FAIL %s tc: observed %b expected %b", tag, tc, exp_tc);
      end
      if (r) begin
         m_val = 0;
      end else if (l) begin
         lo    = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
         hi    = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
         m_val = hi * 10 + lo;
      end else if (e) begin
         m_val = u ? (m_val + 1) % 100 : (m_val + 99) % 100;
      end
      if (r) begin
         m_div = 0;
         m_idx = 0;
      end else if (m_div == 3) begin
         m_div = 0;
         m_idx = (m_idx + 1) % 2;
      end else begin
         m_div = m_div + 1;
      end
      dig      = (m_idx == 0) ? (m_val % 10) : (m_val / 10);
      ex.count = {4'(m_val / 10), 4'(m_val % 10)};
      ex.an    = 2'(1 << m_idx);
      ex.seg   = segtab[dig];
      q.push_back(ex);
      @(posedge clk);
      #1;
      got = q.pop_front();
      tests++;
      assert (count === got.count) else begin
         fails++;
         $error("FAIL %s count: observed %h expected %h", tag, count, got.count);
      end
      tests++;
      assert (an === got.an) else begin
         fails++;
         $error("FAIL %s an: observed %b expected %b", tag, an, got.an);
      end
      tests++;
      assert (seg === got.seg) else begin
         fails++;
         $error("FAIL %s seg: observed %h expected %h", tag, seg, got.seg);
      end
   endtask

   initial begin
      // reset with en high: tc must stay low, state cleared
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "reset");
      // count up through the full range and wrap 99 -> 00
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "up_run");
      // load 00 then count down through the 00 -> 99 wrap
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "load_00");
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "down_run");
      // load beats enable; invalid nibbles load as zero
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h5C, "load_5C");
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, "load_A3");
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h99, "load_99");
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, "load_over_tc");
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "wrap_from_99");
      // hold 37 and watch the display scan
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h37, "load_37");
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "scan_hold");
      // reset mid-count overrides enable, then counting resumes from zero
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h42, "load_42");
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "hold_42");
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, "reset_mid");
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "resume");
      // direction toggling every cycle from 10
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, "load_10");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, (i % 2) == 0, 1'b0, 8'h00, "toggle");
      // hold keeps the value even with direction changing
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "hold_dn");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_bcd_counter.md
SYNC_BCD_COUNTER -- requirements
Module: sync_bcd_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000: clocks per display digit slot; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-005 en  input  1  count enable; one count step per clock while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  4*DIGITS  value to load; digit k occupies bits [4k+3:4k], k=0 is least significant.
REQ-009 count  output  4*DIGITS  registered BCD count value, same digit packing as load_val.
REQ-010 tc  output  1  terminal count: high in the cycle whose next edge wraps the counter.
REQ-011 an  output  DIGITS  one-hot digit select for the display, active-high; bit k selects digit k.
REQ-012 seg  output  7  segment pattern of the selected digit, active-high; seg[0]=a ... seg[6]=g.

Function
REQ-013 Priority per edge: reset > load > en; with en=0 and load=0, count holds.
REQ-014 Load: on each digit, count takes load_val in the following cycle; any nibble > 9 loads as 0 on that digit only.
REQ-015 Up count: digit 0 increments; a digit at 9 wraps to 0 and carries into the next digit, so the count is decimal modulo 10^DIGITS.
REQ-016 Down count: digit 0 decrements; a digit at 0 wraps to 9 and borrows from the next digit.
REQ-017 Full wrap: up from all-9 gives all-0; down from all-0 gives all-9; both take one clock.
REQ-018 tc is combinational: tc = en & ~load & ~reset & (up ? all digits 9 : all digits 0).
REQ-019 A direction change takes effect on the same edge, with no idle cycle.
REQ-020 count is never non-BCD; every digit stays in 0..9 at all times.
REQ-021 Scan divider: a free-running counter from 0 to SCAN_DIV-1, independent of en and load.
REQ-022 At divider value SCAN_DIV-1, the digit index advances (k -> k+1, DIGITS-1 -> 0) and the divider returns to 0.
REQ-023 an = one-hot(digit index), registered; exactly one bit is high at all times.
REQ-024 seg is a combinational decode of the count digit selected by the current index.
REQ-025 seg encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex, bit6..bit0).
REQ-026 A load or count step changes seg in the same cycle that count changes; this adds no scan delay.
REQ-027 DIGITS=1: an is a constant 1 and the counter is a single decade 0..9.

Reset
REQ-028 Reset clears count to 0.
REQ-029 Reset clears the divider to 0.
REQ-030 Reset sets the digit index to 0, so an = 1 (only bit 0 high).
REQ-031 Reset forces tc = 0 and seg = 3F.
REQ-032 Reset mid-count or mid-load overrides en and load on that edge; counting resumes from 0 on the first edge after reset is low.

Verification (DIGITS=2, SCAN_DIV=4)
REQ-033 Apply reset, then en=1, up=1 for 100 clocks -> count steps 00,01..09,10..99,00; tc high only in the cycle count=99.
REQ-034 Apply load=1, load_val=0x00, then en=1, up=0 -> count 99,98..90,89; tc high only in the cycle count=00.
REQ-035 Apply load=1, en=1, load_val=0x5C -> count=0x50 next cycle; invalid low nibble loads as 0 and load wins over en.
REQ-036 Hold count=0x37, run the scan -> an=01 for 4 clocks with seg=7F? no: seg=07 (digit 7), then an=10 for 4 clocks with seg=4F (digit 3); pattern repeats.
REQ-037 Assert reset for 1 clock while count=0x42, en=1 and the divider is mid-slot -> count=00, an=01, seg=3F, divider=0 on the next cycle.
REQ-038 Apply en=1 and toggle up every cycle starting from 0x10 -> count 11,10,11,10; tc stays 0 throughout.
